// File: rtl/key_code_encoder_pkg.sv
// Shared key-code constants, FSM state encoding and the ASCII-to-code map.
// Machine imports the same constants, so the code values live here only.
package game_key_pkg;

   localparam logic [3:0] KEY_IDLE    = 4'b0000;
   localparam logic [3:0] KEY_UP      = 4'b0001;
   localparam logic [3:0] KEY_LEFT    = 4'b0010;
   localparam logic [3:0] KEY_DOWN    = 4'b0011;
   localparam logic [3:0] KEY_RIGHT   = 4'b0100;
   localparam logic [3:0] KEY_CONFIRM = 4'b0101;
   localparam logic [3:0] KEY_CANCEL  = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Letters are folded to lower case first; anything unmapped returns KEY_IDLE.
   function automatic logic [3:0] key_map(input logic [7:0] c);
      logic [7:0] lc;
      lc = ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
      case (lc)
         8'h77:   key_map = KEY_UP;      // 'w'
         8'h61:   key_map = KEY_LEFT;    // 'a'
         8'h73:   key_map = KEY_DOWN;    // 's'
         8'h64:   key_map = KEY_RIGHT;   // 'd'
         8'h20:   key_map = KEY_CONFIRM; // space
         8'h0D:   key_map = KEY_CONFIRM; // carriage return
         8'h78:   key_map = KEY_CANCEL;  // 'x'
         8'h1B:   key_map = KEY_CANCEL;  // escape
         default: key_map = KEY_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/key_code_encoder_if.sv
// Bus between the UART receiver side and the key encoder, plus the
// encoder's outputs towards Machine.
interface key_code_encoder_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] keyboard;
   logic       busy;
   logic       overflow;

   modport master (
      output rx_data, rx_valid,
      input  keyboard, busy, overflow
   );

   modport slave (
      input  rx_data, rx_valid,
      output keyboard, busy, overflow
   );
endinterface

// File: rtl/key_fifo.sv
// Small pending-code FIFO, 4-bit wide, DEPTH a power of two (>= 2).
// Pointers carry one extra wrap bit to tell full from empty. A write while
// full is accepted only when a read happens on the same edge.
module key_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [3:0] din,
   output logic [3:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [3:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_wr, do_rd;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   // Next pointer values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/key_code_encoder.sv
// Turns ASCII key bytes into timed 4-bit command pulses for Machine.
// Each code is driven for PULSE_CYCLES, then keyboard idles for GAP_CYCLES.
// Optional build macro KEY_REPEAT_FILTER_EN drops a code equal to the one
// currently pulsing or to the last code queued (terminal auto-repeat).
module key_code_encoder
   import game_key_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input logic              clk,
   input logic              rst_n,
   key_code_encoder_if.slave bus
);
   localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       key_q, key_d;
   logic             overflow_q, overflow_d;

   logic [3:0] code;
   logic       recog;
   logic       dup;
   logic       accept;
   logic       pop;
   logic       fifo_wr;
   logic       fifo_full, fifo_empty;
   logic [3:0] fifo_dout;

   assign code   = key_map(bus.rx_data);
   assign recog  = bus.rx_valid && (code != KEY_IDLE);
   assign accept = recog && !dup;
   assign pop    = (state_q == ST_IDLE) && !fifo_empty;
   // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
   assign fifo_wr    = accept && (!fifo_full || pop);
   assign overflow_d = accept && fifo_full && !pop;

`ifdef KEY_REPEAT_FILTER_EN
   logic [3:0] last_q, last_d;
   logic       last_vld_q, last_vld_d;

   assign dup = ((state_q == ST_PULSE) && (code == key_q)) ||
                (last_vld_q && (code == last_q));

   // Remember the last queued code; forget it once the encoder goes quiet.
   always_comb begin
      last_d     = last_q;
      last_vld_d = last_vld_q;
      if (fifo_wr) begin
         last_d     = code;
         last_vld_d = 1'b1;
      end else if ((state_q == ST_GAP) && (cnt_q == '0) && fifo_empty) begin
         last_vld_d = 1'b0;
      end
   end

   // Repeat-filter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= KEY_IDLE;
         last_vld_q <= 1'b0;
      end else begin
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
      end
   end
`else
   assign dup = 1'b0;
`endif

   key_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (fifo_wr),
      .rd_en (pop),
      .din   (code),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Pulse/gap sequencer: next state, counter and keyboard value.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               key_d   = fifo_dout;
               cnt_d   = CNT_W'(PULSE_CYCLES - 1);
               state_d = ST_PULSE;
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               key_d   = KEY_IDLE;
               cnt_d   = CNT_W'(GAP_CYCLES - 1);
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            key_d   = KEY_IDLE;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer and output registers; reset forces keyboard idle at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         key_q      <= KEY_IDLE;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         key_q      <= key_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.keyboard = key_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_key_code_encoder.sv
// Scoreboard bench for key_code_encoder: expected codes are queued when the
// stimulus is driven and popped when a new pulse starts on keyboard.
module tb_key_code_encoder;

   localparam int P = 4;
   localparam int G = 2;
   localparam int D = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   key_code_encoder_if kif();

   key_code_encoder #(
      .PULSE_CYCLES (P),
      .GAP_CYCLES   (G),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (kif)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] sb[$];
   logic [7:0] tx[$];
   int         ovf_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive the queued bytes on consecutive cycles, one rx_valid each.
   task automatic send_tx();
      foreach (tx[i]) begin
         @(negedge clk);
         kif.rx_data  = tx[i];
         kif.rx_valid = 1'b1;
      end
      @(negedge clk);
      kif.rx_valid = 1'b0;
      tx.delete();
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (kif.busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, kif.busy, 0);
   endtask

   // Output monitor.
   int         cyc = 0;
   int         width = 0;
   int         last_start = 0;
   bit         have_start = 0;
   logic [3:0] prev_kb = 4'd0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_kb    = 4'd0;
         width      = 0;
         have_start = 0;
      end else begin
         if (kif.overflow === 1'b1) ovf_cnt++;
         if (kif.keyboard != 4'd0 && prev_kb == 4'd0) begin
            if (sb.size() == 0) chk("unexpected_code", kif.keyboard, 0);
            else                chk("code", kif.keyboard, sb.pop_front());
            if (have_start) chk("spacing_ge_min", ((cyc - last_start) >= (P + G + 1)), 1);
            last_start = cyc;
            have_start = 1;
            width      = 1;
         end else if (kif.keyboard != 4'd0) begin
            width++;
         end else if (prev_kb != 4'd0) begin
            chk("pulse_width", width, P);
         end
         prev_kb = kif.keyboard;
      end
   end

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  busy_seen;

      kif.rx_data  = 8'h00;
      kif.rx_valid = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_keyboard", kif.keyboard, 0);
      chk("rst_busy",     kif.busy,     0);
      chk("rst_overflow", kif.overflow, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_keyboard", kif.keyboard, 0);

      // Single key with exact latency and busy duration
      sb.push_back(4'b0001);
      tx.push_back(8'h77);
      send_tx();
      chk("lat_write_edge", kif.keyboard, 0);
      chk("lat_busy_after_write", kif.busy, 1);
      @(negedge clk);
      chk("lat_drive_edge", kif.keyboard, 4'b0001);
      wait_idle("single_idle", n);
      chk("single_busy_cycles", n, P + G);
      chk("single_drain", sb.size(), 0);

      // Burst of four keys
      ovf_cnt = 0;
      sb.push_back(4'b0010); sb.push_back(4'b0011);
      sb.push_back(4'b0100); sb.push_back(4'b0101);
      tx.push_back(8'h61); tx.push_back(8'h73);
      tx.push_back(8'h64); tx.push_back(8'h20);
      send_tx();
      wait_idle("burst_idle", n);
      chk("burst_drain", sb.size(), 0);
      chk("burst_no_ovf", ovf_cnt, 0);

      // Overflow: six keys back to back, the sixth dropped
      ovf_cnt = 0;
      sb.push_back(4'b0001); sb.push_back(4'b0010); sb.push_back(4'b0011);
      sb.push_back(4'b0100); sb.push_back(4'b0110);
      tx.push_back(8'h77); tx.push_back(8'h61); tx.push_back(8'h73);
      tx.push_back(8'h64); tx.push_back(8'h78); tx.push_back(8'h20);
      send_tx();
      wait_idle("ovf_idle", n);
      repeat (3) @(negedge clk);
      chk("ovf_pulse_cycles", ovf_cnt, 1);
      chk("ovf_drain", sb.size(), 0);

      // Full FIFO with a write on the pop edge: write accepted, no overflow
      ovf_cnt = 0;
      sb.push_back(4'b0001); sb.push_back(4'b0010); sb.push_back(4'b0011);
      sb.push_back(4'b0100); sb.push_back(4'b0110); sb.push_back(4'b0101);
      tx.push_back(8'h77); tx.push_back(8'h61); tx.push_back(8'h73);
      tx.push_back(8'h64); tx.push_back(8'h78);
      tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h00);
      tx.push_back(8'h20);
      send_tx();
      wait_idle("fullpop_idle", n);
      chk("fullpop_no_ovf", ovf_cnt, 0);
      chk("fullpop_drain", sb.size(), 0);

      // Ignored bytes
      ovf_cnt   = 0;
      busy_seen = 0;
      tx.push_back(8'h71); tx.push_back(8'h00); tx.push_back(8'hFF);
      send_tx();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (kif.busy !== 1'b0) busy_seen = 1;
      end
      chk("ignore_busy", busy_seen, 0);
      chk("ignore_ovf", ovf_cnt, 0);
      chk("ignore_keyboard", kif.keyboard, 0);

      // Upper case and control-byte aliases
      sb.push_back(4'b0001); tx.push_back(8'h57); send_tx(); wait_idle("alias_W", n);
      sb.push_back(4'b0101); tx.push_back(8'h0D); send_tx(); wait_idle("alias_cr", n);
      sb.push_back(4'b0110); tx.push_back(8'h1B); send_tx(); wait_idle("alias_esc", n);
      sb.push_back(4'b0110); tx.push_back(8'h58); send_tx(); wait_idle("alias_X", n);
      sb.push_back(4'b0100); tx.push_back(8'h44); send_tx(); wait_idle("alias_D", n);
      chk("alias_drain", sb.size(), 0);

      // Reset during a pulse discards the queued code
      sb.push_back(4'b0100);
      tx.push_back(8'h64); tx.push_back(8'h78);
      send_tx();
      n = 0;
      while (kif.keyboard !== 4'b0100 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_saw_pulse", kif.keyboard, 4'b0100);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_keyboard_async", kif.keyboard, 0);
      chk("rst_mid_busy_async", kif.busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_mid_busy_after", kif.busy, 0);
      chk("rst_mid_drain", sb.size(), 0);

      // Auto-repeat sequence
      sb.push_back(4'b0001);
`ifndef KEY_REPEAT_FILTER_EN
      sb.push_back(4'b0001);
      sb.push_back(4'b0001);
`endif
      sb.push_back(4'b0011);
      tx.push_back(8'h77); tx.push_back(8'h77);
      tx.push_back(8'h77); tx.push_back(8'h73);
      send_tx();
      wait_idle("repeat_idle", n);
      chk("repeat_drain", sb.size(), 0);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
